// File: rtl/mpeg_sd_streamer_if.sv
// mpeg_sd_streamer_if: hps_io SD block port and output byte-stream bundles
interface sd_blk_if;
  logic        img_mounted;
  logic [63:0] img_size;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [13:0] sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  modport master (
    input  img_mounted, img_size, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    output sd_lba, sd_blk_cnt, sd_rd, sd_wr
  );
  modport slave (
    output img_mounted, img_size, sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
    input  sd_lba, sd_blk_cnt, sd_rd, sd_wr
  );
endinterface

interface byte_stream_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave (input out_data, out_valid, out_last, output out_ready);
endinterface

// File: rtl/mpeg_sd_streamer.sv
// mpeg_sd_streamer: sequential sector reader with ping-pong buffers feeding a valid/ready byte stream
module mpeg_sd_streamer #(
  parameter logic [31:0] START_LBA = 32'd0
) (
  input  logic           clk_sys,
  input  logic           reset,
  sd_blk_if.master       sd,
  byte_stream_if.master  st,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;
  state_t      state_q;
  logic [7:0]  mem [0:1023];
  logic [40:0] size_q, cnt_q;
  logic [32:0] total_q, issued_q;
  logic [9:0]  len_q [2];
  logic [1:0]  full_q;
  logic        fill_q, drain_q, discard_q, busy_q, rd_q, valid_q, last_q;
  logic [31:0] lba_q;
  logic [7:0]  data_q;
  logic [8:0]  ptr_q;
  logic        wr_en, load, last_sec;
  logic [9:0]  tail_len;
  logic        unused_hi;

  assign unused_hi     = ^sd.img_size[63:41];
  assign sd.sd_lba     = lba_q;
  assign sd.sd_rd      = rd_q;
  assign sd.sd_wr      = 1'b0;
  assign sd.sd_blk_cnt = 6'd0;
  assign st.out_data   = data_q;
  assign st.out_valid  = valid_q;
  assign st.out_last   = last_q;
  assign busy          = busy_q;

  assign wr_en    = state_q == XFER && sd.sd_ack && sd.sd_buff_wr && sd.sd_buff_addr[13:9] == 5'd0 && !discard_q;
  assign load     = full_q[drain_q] && (!valid_q || st.out_ready);
  assign last_sec = issued_q == total_q - 33'd1;
  assign tail_len = size_q[8:0] == 9'd0 ? 10'd512 : {1'b0, size_q[8:0]};

  always_ff @(posedge clk_sys)
    if (wr_en) mem[{fill_q, sd.sd_buff_addr[8:0]}] <= sd.sd_buff_dout;

  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q   <= IDLE;
      size_q    <= '0;
      cnt_q     <= '0;
      total_q   <= '0;
      issued_q  <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      full_q    <= '0;
      fill_q    <= 1'b0;
      drain_q   <= 1'b0;
      discard_q <= 1'b0;
      busy_q    <= 1'b0;
      rd_q      <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      lba_q     <= '0;
      data_q    <= '0;
      ptr_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (busy_q && issued_q < total_q && !full_q[fill_q] && !sd.img_mounted) begin
          state_q <= REQ;
          rd_q    <= 1'b1;
          lba_q   <= START_LBA + issued_q[31:0];
        end
        REQ: if (sd.sd_ack) begin
          state_q <= XFER;
          rd_q    <= 1'b0;
        end
        XFER: if (!sd.sd_ack) state_q <= DONE;
        default: begin
          if (!discard_q) begin
            full_q[fill_q] <= 1'b1;
            len_q[fill_q]  <= last_sec ? tail_len : 10'd512;
            issued_q       <= issued_q + 33'd1;
            fill_q         <= !fill_q;
          end
          discard_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
      if (load) begin
        data_q  <= mem[{drain_q, ptr_q}];
        valid_q <= 1'b1;
        last_q  <= cnt_q == size_q - 41'd1;
        cnt_q   <= cnt_q + 41'd1;
        if ({1'b0, ptr_q} == len_q[drain_q] - 10'd1) begin
          ptr_q           <= '0;
          full_q[drain_q] <= 1'b0;
          drain_q         <= !drain_q;
        end else ptr_q <= ptr_q + 9'd1;
      end else if (st.out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      if (valid_q && st.out_ready && last_q) busy_q <= 1'b0;
      // A mount overrides everything above; an in-flight hps_io transfer is finished but its data dropped
      if (sd.img_mounted) begin
        size_q    <= sd.img_size[40:0];
        total_q   <= {1'b0, sd.img_size[40:9]} + {32'd0, |sd.img_size[8:0]};
        issued_q  <= '0;
        full_q    <= '0;
        fill_q    <= 1'b0;
        drain_q   <= 1'b0;
        ptr_q     <= '0;
        cnt_q     <= '0;
        valid_q   <= 1'b0;
        last_q    <= 1'b0;
        busy_q    <= |sd.img_size[40:0];
        discard_q <= state_q == REQ || state_q == XFER;
      end
    end
endmodule
